comp_sar_search: RTL and testbench

Successive-approximation search engine that drives the comparand port of the team's 4-output comparator (`gt`, `aeq`, `eq`, `lt`). It locates the hidden operand `a` by binary search on the probe value `guess`. Proximity hits (`aeq`) hand off to a bounded linear fine search. It sits opposite the comparator: it drives `b`, consumes the flag vector, and reports the located value, a near-hit and a probe count.

---
 rtl/comp_sar_search.sv | 179 +++++++++++++++++
 tb/tb_comp_sar_search.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/comp_sar_search.sv
// Successive-approximation search engine driving the comparand of a 4-flag
// comparator; binary search with a bounded linear fine search around proximity hits.
module comp_sar_search #(
   parameter int W   = 4,
   parameter int TOL = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         gt,
   input  logic         aeq,
   input  logic         eq,
   input  logic         lt,
   output logic [W-1:0] guess,
   output logic         busy,
   output logic         done,
   output logic         found,
   output logic         error,
   output logic [W-1:0] result,
   output logic [W-1:0] near,
   output logic         near_valid,
   output logic [7:0]   probes
);

   // Handshake: start is accepted only in IDLE; busy is high while probing,
   // done pulses one cycle with found/error/result valid, busy low during done.
   typedef enum logic [1:0] {IDLE, SEARCH, FINE, DONE} state_t;
   typedef logic signed [W+1:0] wide_t;

   localparam logic signed [W:0] MAX_S = (W+1)'((1 << W) - 1);
   localparam wide_t             MAX_W = (W+2)'((1 << W) - 1);
   localparam wide_t             TOL_W = (W+2)'(TOL);
   localparam logic [W-1:0]      MID   = W'(((1 << W) - 1) >> 1);

   state_t            state, state_n;
   logic signed [W:0] lo, lo_n, hi, hi_n, cmax, cmax_n;
   logic [W-1:0]      centre, centre_n, guess_n, result_n, near_n;
   logic              found_n, error_n, near_valid_n;
   logic [7:0]        probes_n, probes_inc;

   logic [3:0] flags;
   logic       onehot;
   wide_t      g_w, lo_w, hi_w, cmax_w, centre_w;
   wide_t      bump, drop, lo_c, hi_c, first_c, next_c;
   logic [W:0] sum_gt, sum_lt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         guess      <= '0;
         lo         <= '0;
         hi         <= MAX_S;
         cmax       <= '0;
         centre     <= '0;
         found      <= 1'b0;
         error      <= 1'b0;
         result     <= '0;
         near       <= '0;
         near_valid <= 1'b0;
         probes     <= '0;
      end else begin
         state      <= state_n;
         guess      <= guess_n;
         lo         <= lo_n;
         hi         <= hi_n;
         cmax       <= cmax_n;
         centre     <= centre_n;
         found      <= found_n;
         error      <= error_n;
         result     <= result_n;
         near       <= near_n;
         near_valid <= near_valid_n;
         probes     <= probes_n;
      end
   end

   // Bound arithmetic runs one bit wider than lo/hi so guess+TOL cannot wrap.
   always_comb begin
      flags      = {gt, aeq, eq, lt};
      onehot     = (flags != 4'd0) && ((flags & (flags - 4'd1)) == 4'd0);
      g_w        = wide_t'({2'b00, guess});
      lo_w       = wide_t'(lo);
      hi_w       = wide_t'(hi);
      cmax_w     = wide_t'(cmax);
      centre_w   = wide_t'({2'b00, centre});
      bump       = g_w + wide_t'(1);
      drop       = g_w - wide_t'(1);
      sum_gt     = bump[W:0] + {1'b0, hi[W-1:0]};
      sum_lt     = {1'b0, lo[W-1:0]} + drop[W:0];
      lo_c       = (g_w - TOL_W < 0) ? wide_t'(0) : g_w - TOL_W;
      hi_c       = (g_w + TOL_W > MAX_W) ? MAX_W : g_w + TOL_W;
      first_c    = (lo_c == g_w) ? lo_c + wide_t'(1) : lo_c;
      next_c     = (bump == centre_w) ? bump + wide_t'(1) : bump;
      probes_inc = (probes == 8'hFF) ? probes : probes + 8'd1;

      state_n      = state;
      guess_n      = guess;
      lo_n         = lo;
      hi_n         = hi;
      cmax_n       = cmax;
      centre_n     = centre;
      found_n      = found;
      error_n      = error;
      result_n     = result;
      near_n       = near;
      near_valid_n = near_valid;
      probes_n     = probes;

      case (state)
         IDLE: begin
            lo_n = '0;
            hi_n = MAX_S;
            if (start) begin
               state_n      = SEARCH;
               guess_n      = MID;
               probes_n     = '0;
               found_n      = 1'b0;
               error_n      = 1'b0;
               near_valid_n = 1'b0;
            end
         end
         SEARCH: begin
            probes_n = probes_inc;
            if (!onehot) begin
               state_n = DONE;
               error_n = 1'b1;
            end else if (eq) begin
               state_n  = DONE;
               found_n  = 1'b1;
               result_n = guess;
            end else if (gt) begin
               if (bump > hi_w) begin
                  state_n = DONE;
                  error_n = 1'b1;
               end else begin
                  lo_n    = bump[W:0];
                  guess_n = sum_gt[W:1];
               end
            end else if (lt) begin
               if (lo_w > drop) begin
                  state_n = DONE;
                  error_n = 1'b1;
               end else begin
                  hi_n    = drop[W:0];
                  guess_n = sum_lt[W:1];
               end
            end else begin
               near_n       = guess;
               near_valid_n = 1'b1;
               centre_n     = guess;
               cmax_n       = hi_c[W:0];
               guess_n      = first_c[W-1:0];
               state_n      = FINE;
            end
         end
         FINE: begin
            probes_n = probes_inc;
            if (!onehot) begin
               state_n = DONE;
               error_n = 1'b1;
            end else if (eq) begin
               state_n  = DONE;
               found_n  = 1'b1;
               result_n = guess;
            end else if (next_c > cmax_w) begin
               state_n = DONE;
               error_n = 1'b1;
            end else begin
               guess_n = next_c[W-1:0];
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign busy = (state == SEARCH) || (state == FINE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_comp_sar_search.sv
// Directed bench for comp_sar_search (W=4, TOL=1) with a behavioural
// comparator model and hand-computed guess traces.
module tb_comp_sar_search;
   localparam int W   = 4;
   localparam int TOL = 1;

   logic         clk, rst, start;
   logic         gt, aeq, eq, lt;
   logic [W-1:0] guess, result, near;
   logic         busy, done, found, error, near_valid;
   logic [7:0]   probes;

   logic [W-1:0] a_val;
   logic         force_en;
   logic [3:0]   force_flags;

   int n_vec = 0;
   int n_err = 0;
   int cycles;
   int extra_done;
   logic got_done;
   logic [W-1:0] exp_q[$];

   comp_sar_search #(.W(W), .TOL(TOL)) dut (
      .clk(clk), .rst(rst), .start(start),
      .gt(gt), .aeq(aeq), .eq(eq), .lt(lt),
      .guess(guess), .busy(busy), .done(done), .found(found), .error(error),
      .result(result), .near(near), .near_valid(near_valid), .probes(probes)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // comparator model
   always_comb begin
      int diff;
      diff = int'(a_val) - int'(guess);
      if (force_en) begin
         {gt, aeq, eq, lt} = force_flags;
      end else begin
         eq  = (diff == 0);
         aeq = (diff != 0) && (diff <= TOL) && (diff >= -TOL);
         gt  = (diff > TOL);
         lt  = (diff < -TOL);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_guess"},  32'(guess), 0);
      check({tag, "_busy"},   32'(busy), 0);
      check({tag, "_done"},   32'(done), 0);
      check({tag, "_found"},  32'(found), 0);
      check({tag, "_error"},  32'(error), 0);
      check({tag, "_result"}, 32'(result), 0);
      check({tag, "_near"},   32'(near), 0);
      check({tag, "_nearv"},  32'(near_valid), 0);
      check({tag, "_probes"}, 32'(probes), 0);
   endtask

   // Drives one search; checks each probed guess against exp_q. Returns with
   // the bench parked on the negedge where done is high. mid_start > 0 pulses
   // start again during that probe cycle.
   task automatic run_search(input logic [W-1:0] a_in, input int mid_start);
      a_val    = a_in;
      got_done = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      cycles = 1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         start = (i + 1 == mid_start);
         if (done) begin
            got_done = 1'b1;
            break;
         end
         if (busy && exp_q.size() > 0) check("guess", 32'(guess), 32'(exp_q.pop_front()));
         @(posedge clk);
         cycles++;
      end
      start = 1'b0;
      check("done_seen", 32'(got_done), 1);
      check("guess_left", 32'(exp_q.size()), 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; a_val = '0;
      force_en = 1'b0; force_flags = 4'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_values("rst");
      rst = 1'b0;
      @(negedge clk);
      check("idle_busy", 32'(busy), 0);

      // a=13: 7 gt, 11 gt, 13 eq
      exp_q = '{4'd7, 4'd11, 4'd13};
      run_search(4'd13, 0);
      check("a13_latency", 32'(cycles), 4);
      check("a13_found", 32'(found), 1);
      check("a13_result", 32'(result), 13);
      check("a13_probes", 32'(probes), 3);
      check("a13_nearv", 32'(near_valid), 0);
      check("a13_busy", 32'(busy), 0);

      // a=0: 7 lt, 3 lt, 1 aeq, fine 0 eq
      exp_q = '{4'd7, 4'd3, 4'd1, 4'd0};
      run_search(4'd0, 0);
      check("a0_found", 32'(found), 1);
      check("a0_result", 32'(result), 0);
      check("a0_near", 32'(near), 1);
      check("a0_nearv", 32'(near_valid), 1);
      check("a0_probes", 32'(probes), 4);

      // a=15: 7, 11, 13 gt, 14 aeq, fine 13 gt, 15 eq (14 skipped)
      exp_q = '{4'd7, 4'd11, 4'd13, 4'd14, 4'd13, 4'd15};
      run_search(4'd15, 0);
      check("a15_found", 32'(found), 1);
      check("a15_result", 32'(result), 15);
      check("a15_near", 32'(near), 14);
      check("a15_probes", 32'(probes), 6);

      // invalid flag vectors on the first probe
      force_en = 1'b1; force_flags = 4'b0000;
      exp_q = '{4'd7};
      run_search(4'd5, 0);
      check("zero_error", 32'(error), 1);
      check("zero_found", 32'(found), 0);
      check("zero_probes", 32'(probes), 1);
      force_flags = 4'b1001;
      exp_q = '{4'd7};
      run_search(4'd5, 0);
      check("gtlt_error", 32'(error), 1);
      check("gtlt_found", 32'(found), 0);
      check("gtlt_probes", 32'(probes), 1);
      force_en = 1'b0;
      @(negedge clk);

      // reset at the second probe of a=9
      a_val = 4'd9;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check("rst_mid_busy", 32'(busy), 1);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset_values("abort");
      rst = 1'b0;
      extra_done = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (done) extra_done++;
      end
      check("abort_no_done", 32'(extra_done), 0);

      // start pulsed mid-search is ignored: 7 gt, 11 lt, 9 eq
      exp_q = '{4'd7, 4'd11, 4'd9};
      run_search(4'd9, 1);
      check("a9_result", 32'(result), 9);
      check("a9_probes", 32'(probes), 3);
      extra_done = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done) extra_done++;
      end
      check("a9_single_done", 32'(extra_done), 0);

      // sweep
      for (int v = 0; v < 16; v++) begin
         run_search(W'(v), 0);
         check("sweep_found", 32'(found), 1);
         check("sweep_result", 32'(result), 32'(v));
         check("sweep_probes_le7", 32'(probes <= 8'd7), 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
